wm_coin_acceptor: RTL and testbench
===================================

// Module: wm_coin_acceptor
// PURPOSE
//  Payment front-end sitting directly upstream of the washing-machine controller. Synchronises the raw
//  coin and cancel inputs, accumulates credit, latches the user's mode, and issues the one-cycle `coin`
//  strobe plus a stable `mode` once credit covers the mode's price. Watches controller status
//  (idle_op/soak_op/coin_rtn) to finalise the sale, or refunds credit as a train of refund pulses.
// PARAMETERS
//  CREDIT_W     4    width of credit counter; MAX_CREDIT = 2**CREDIT_W-1
//  PRICE_M1     2    coin units for MODE1
//  PRICE_M2     3    coin units for MODE2
//  PRICE_M3     5    coin units for MODE3
//  ARM_TIMEOUT  16   cycles in ARMED without soak_op/coin_rtn before auto-refund (>=4)
//  REFUND_GAP   4    refund_pulse period in cycles (>=2)
//  CHANGE_EN    1    1: residual credit refunded when soak_op seen; 0: residual kept
// PORTS
//  clk           in   1         system clock, rising edge
//  rst_n         in   1         asynchronous active-low reset
//  coin_in       in   1         raw coin-slot sensor, async, one rising edge per coin
//  cancel_btn    in   1         raw user cancel, async
//  mode_key      in   2         mode selector (00/01/10 valid, 11 ignored)
//  idle_op       in   1         controller in IDLE
//  soak_op       in   1         controller in SOAK (sale complete)
//  coin_rtn      in   1         controller requests return (cancel in READY)
//  coin          out  1         one-cycle strobe to controller: paid, start
//  mode          out  2         latched mode to controller
//  credit        out  CREDIT_W  current unspent credit
//  refund_pulse  out  1         one pulse per coin unit returned
//  coin_reject   out  1         one-cycle pulse: coin not accepted (credit full or refunding)
//  busy          out  1         high in ISSUE/ARMED/REFUND
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=COLLECT; coin=0, mode=00, credit=0, refund_pulse=0, coin_reject=0,
//    busy=0; sync flops, arm_cnt, refund_cnt, gap_cnt cleared. Reset mid-operation discards credit/refunds.
//  - coin_in, cancel_btn: 2-FF sync + rising-edge detect; event valid 2 clks after first sampling edge,
//    acted on at 3rd edge. Level held high = one event only.
//  - All outputs registered. price = PRICE_M1/M2/M3 selected by mode.
//  - States COLLECT, ISSUE, ARMED, REFUND (2-bit encoding):
//    COLLECT: mode <= mode_key unless 11. coin_evt: credit+1, or coin_reject if credit==MAX_CREDIT.
//      cancel_evt with credit>0 -> REFUND, refund_cnt=credit, credit=0; cancel with credit=0 ignored.
//      else credit>=price && idle_op -> ISSUE. cancel has priority over ISSUE.
//    ISSUE (1 cycle): coin=1, credit <= credit - price (+1 if same-cycle coin_evt), arm_cnt=0 -> ARMED.
//      mode frozen from ISSUE until return to COLLECT.
//    ARMED: coins accepted as in COLLECT; cancel_btn ignored (controller owns cancel).
//      priority 1 coin_rtn=1 or arm_cnt==ARM_TIMEOUT-1: refund_cnt=price+credit(+1 same-cycle coin),
//        credit=0 -> REFUND.
//      priority 2 soak_op=1: CHANGE_EN && credit>0 -> REFUND with refund_cnt=credit, credit=0; else COLLECT.
//    REFUND: refund_pulse high 1 cycle at gap_cnt==0, then low REFUND_GAP-1 cycles; refund_cnt-- per pulse;
//      after last pulse's gap -> COLLECT. Coins during REFUND -> coin_reject, not credited.
//  - refund_cnt width CREDIT_W+3 (price+MAX_CREDIT never wraps). credit never wraps or underflows.
//  - coin and refund_pulse never high in same cycle; coin_reject exactly 1 cycle per rejected coin.
// STRUCTURE
//  - wm_pkg: mode encodings MODE1/2/3 (00/01/10), default prices, acceptor state enum; shared with
//    controller so mode codes stay consistent.
//  - Sub-module wm_sync_edge (2-FF synchroniser + rising-edge pulse, async active-low reset),
//    instantiated twice (coin_in, cancel_btn). FSM, credit and refund counters in top.
// TESTING
//  1 mode_key=00, 2 coins, idle_op=1 -> coin pulse 1 cycle, mode=00, credit=0, busy=1; soak_op -> COLLECT.
//  2 mode_key=10, 7 coins, soak_op after coin, CHANGE_EN=1 -> exactly 2 refund_pulse spaced 4 cycles.
//  3 mode_key=01, 3 coins -> coin; coin_rtn pulse in ARMED -> 3 refund_pulse, credit=0, then busy=0.
//  4 ARMED with no controller response -> auto-refund after 16 cycles, refund count = price.
//  5 16 coins in COLLECT, mode=10, idle_op=0 -> credit=15, 16th gives coin_reject; cancel_btn -> 15 pulses.
//  6 rst_n low mid-REFUND -> all outputs 0 immediately (async), no pulses after release; cancel held high -> one event.

Source files
------------

// File: rtl/wm_pkg.sv
// Shared washing-machine definitions: mode codes, default prices and the
// coin-acceptor state encoding used by both the acceptor and the controller.
package wm_pkg;

    localparam logic [1:0] MODE1     = 2'b00;
    localparam logic [1:0] MODE2     = 2'b01;
    localparam logic [1:0] MODE3     = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;

    localparam int PRICE_M1_DEF = 2;
    localparam int PRICE_M2_DEF = 3;
    localparam int PRICE_M3_DEF = 5;

    typedef enum logic [1:0] {
        ACC_COLLECT = 2'b00,
        ACC_ISSUE   = 2'b01,
        ACC_ARMED   = 2'b10,
        ACC_REFUND  = 2'b11
    } acc_state_t;

endpackage

// File: rtl/wm_sync_edge.sv
// Two-flop synchroniser for an asynchronous level input, followed by a
// rising-edge detector; a level held high yields a single one-cycle pulse.
module wm_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign pulse = sync_r & ~prev_r;

endmodule

// File: rtl/wm_coin_acceptor.sv
// Coin acceptor: collects credit, issues a paid strobe with the latched mode
// when credit covers the price, and refunds credit as a train of pulses.
module wm_coin_acceptor
    import wm_pkg::*;
#(
    parameter int CREDIT_W    = 4,
    parameter int PRICE_M1    = PRICE_M1_DEF,
    parameter int PRICE_M2    = PRICE_M2_DEF,
    parameter int PRICE_M3    = PRICE_M3_DEF,
    parameter int ARM_TIMEOUT = 16,
    parameter int REFUND_GAP  = 4,
    parameter int CHANGE_EN   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_in,
    input  logic                cancel_btn,
    input  logic [1:0]          mode_key,
    input  logic                idle_op,
    input  logic                soak_op,
    input  logic                coin_rtn,
    output logic                coin,
    output logic [1:0]          mode,
    output logic [CREDIT_W-1:0] credit,
    output logic                refund_pulse,
    output logic                coin_reject,
    output logic                busy
);

    localparam int RW = CREDIT_W + 3;
    localparam int AW = $clog2(ARM_TIMEOUT) + 1;
    localparam int GW = $clog2(REFUND_GAP) + 1;

    localparam logic [CREDIT_W-1:0] MAX_CREDIT = {CREDIT_W{1'b1}};
    localparam logic [RW-1:0]       P1         = RW'(PRICE_M1);
    localparam logic [RW-1:0]       P2         = RW'(PRICE_M2);
    localparam logic [RW-1:0]       P3         = RW'(PRICE_M3);
    localparam logic [RW-1:0]       RC_ONE     = RW'(1);
    localparam logic [AW-1:0]       ARM_LAST   = AW'(ARM_TIMEOUT - 1);
    localparam logic [AW-1:0]       ARM_ONE    = AW'(1);
    localparam logic [GW-1:0]       GAP_LAST   = GW'(REFUND_GAP - 1);
    localparam logic [GW-1:0]       GAP_ONE    = GW'(1);

    acc_state_t          state_r, state_s;
    logic [CREDIT_W-1:0] credit_r, credit_s, credit_inc_s;
    logic [1:0]          mode_r, mode_s;
    logic [RW-1:0]       refund_cnt_r, refund_cnt_s;
    logic [AW-1:0]       arm_cnt_r, arm_cnt_s;
    logic [GW-1:0]       gap_cnt_r, gap_cnt_s;
    logic                coin_r, coin_s;
    logic                refund_pulse_r, refund_pulse_s;
    logic                coin_reject_r, coin_reject_s;
    logic                busy_r, busy_s;
    logic                coin_evt_s, cancel_evt_s;
    logic                credit_full_s, coin_ok_s;
    logic [RW-1:0]       price_s, cur_ext_s, inc_ext_s;

    wm_sync_edge u_coin_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (coin_in),
        .pulse (coin_evt_s)
    );

    wm_sync_edge u_cancel_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cancel_btn),
        .pulse (cancel_evt_s)
    );

    // Price of the currently latched mode.
    always_comb begin
        price_s = P1;
        case (mode_r)
            MODE2:   price_s = P2;
            MODE3:   price_s = P3;
            default: price_s = P1;
        endcase
    end

    // Next-state, credit, counter and output decode.
    always_comb begin
        state_s        = state_r;
        credit_s       = credit_r;
        mode_s         = mode_r;
        refund_cnt_s   = refund_cnt_r;
        arm_cnt_s      = arm_cnt_r;
        gap_cnt_s      = gap_cnt_r;
        coin_reject_s  = 1'b0;
        credit_full_s  = (credit_r == MAX_CREDIT);
        coin_ok_s      = coin_evt_s & ~credit_full_s;
        credit_inc_s   = credit_r + {{(CREDIT_W-1){1'b0}}, coin_ok_s};
        cur_ext_s      = {3'b000, credit_r};
        inc_ext_s      = {3'b000, credit_inc_s};

        case (state_r)
            ACC_COLLECT: begin
                coin_reject_s = coin_evt_s & credit_full_s;
                credit_s      = credit_inc_s;
                if (cancel_evt_s && (credit_r != '0)) begin
                    state_s      = ACC_REFUND;
                    refund_cnt_s = inc_ext_s;
                    credit_s     = '0;
                    gap_cnt_s    = '0;
                end else if ((cur_ext_s >= price_s) && idle_op) begin
                    // Mode is frozen from here so the strobe and price agree.
                    state_s = ACC_ISSUE;
                end else begin
                    if (mode_key != MODE_NONE) begin
                        mode_s = mode_key;
                    end else begin
                        mode_s = mode_r;
                    end
                end
            end
            ACC_ISSUE: begin
                coin_reject_s = coin_evt_s & credit_full_s;
                credit_s      = CREDIT_W'(inc_ext_s - price_s);
                arm_cnt_s     = '0;
                state_s       = ACC_ARMED;
            end
            ACC_ARMED: begin
                coin_reject_s = coin_evt_s & credit_full_s;
                credit_s      = credit_inc_s;
                arm_cnt_s     = arm_cnt_r + ARM_ONE;
                if (coin_rtn || (arm_cnt_r == ARM_LAST)) begin
                    state_s      = ACC_REFUND;
                    refund_cnt_s = price_s + inc_ext_s;
                    credit_s     = '0;
                    gap_cnt_s    = '0;
                end else if (soak_op) begin
                    if ((CHANGE_EN != 0) && (credit_inc_s != '0)) begin
                        state_s      = ACC_REFUND;
                        refund_cnt_s = inc_ext_s;
                        credit_s     = '0;
                        gap_cnt_s    = '0;
                    end else begin
                        state_s = ACC_COLLECT;
                    end
                end else begin
                    state_s = ACC_ARMED;
                end
            end
            ACC_REFUND: begin
                coin_reject_s = coin_evt_s;
                if (gap_cnt_r == '0) begin
                    if (refund_cnt_r != '0) begin
                        refund_cnt_s = refund_cnt_r - RC_ONE;
                    end else begin
                        refund_cnt_s = refund_cnt_r;
                    end
                    gap_cnt_s = GAP_ONE;
                end else if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_s = '0;
                    if (refund_cnt_r == '0) begin
                        state_s = ACC_COLLECT;
                    end else begin
                        state_s = ACC_REFUND;
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_ONE;
                end
            end
            default: begin
                state_s  = ACC_COLLECT;
                credit_s = '0;
            end
        endcase

        coin_s         = (state_s == ACC_ISSUE);
        busy_s         = (state_s != ACC_COLLECT);
        refund_pulse_s = (state_s == ACC_REFUND) && (gap_cnt_s == '0) && (refund_cnt_s != '0);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ACC_COLLECT;
            credit_r       <= '0;
            mode_r         <= MODE1;
            refund_cnt_r   <= '0;
            arm_cnt_r      <= '0;
            gap_cnt_r      <= '0;
            coin_r         <= 1'b0;
            refund_pulse_r <= 1'b0;
            coin_reject_r  <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            credit_r       <= credit_s;
            mode_r         <= mode_s;
            refund_cnt_r   <= refund_cnt_s;
            arm_cnt_r      <= arm_cnt_s;
            gap_cnt_r      <= gap_cnt_s;
            coin_r         <= coin_s;
            refund_pulse_r <= refund_pulse_s;
            coin_reject_r  <= coin_reject_s;
            busy_r         <= busy_s;
        end
    end

    assign coin         = coin_r;
    assign mode         = mode_r;
    assign credit       = credit_r;
    assign refund_pulse = refund_pulse_r;
    assign coin_reject  = coin_reject_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_wm_coin_acceptor.sv
// Bench for wm_coin_acceptor: transaction-level expectations are queued by the
// stimulus and consumed by an independent output monitor.
module tb_wm_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_in = 1'b0;
    logic       cancel_btn = 1'b0;
    logic [1:0] mode_key = 2'b00;
    logic       idle_op = 1'b0;
    logic       soak_op = 1'b0;
    logic       coin_rtn = 1'b0;
    logic       coin;
    logic [1:0] mode;
    logic [3:0] credit;
    logic       refund_pulse;
    logic       coin_reject;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int count;
        int first_delay;
    } refund_exp_t;

    refund_exp_t refund_q[$];
    int          coin_q[$];
    int          reject_q[$];

    always #5 clk = ~clk;

    wm_coin_acceptor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_in      (coin_in),
        .cancel_btn   (cancel_btn),
        .mode_key     (mode_key),
        .idle_op      (idle_op),
        .soak_op      (soak_op),
        .coin_rtn     (coin_rtn),
        .coin         (coin),
        .mode         (mode),
        .credit       (credit),
        .refund_pulse (refund_pulse),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    function automatic int price_of(input int m);
        return (m == 0) ? 2 : (m == 1) ? 3 : 5;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: consumes queued expectations as the DUT produces events.
    int          burst_pulses = 0;
    int          last_pulse_cyc = 0;
    int          first_pulse_cyc = 0;
    int          coin_cyc = 0;
    logic        busy_d = 1'b0;
    logic        coin_d = 1'b0;
    logic        reject_d = 1'b0;
    int          exp_mode;
    refund_exp_t exp_ref;

    always @(negedge clk) begin
        cyc++;
        if (coin && refund_pulse) check("coin_refund_overlap", 1, 0);
        if (coin) begin
            check("coin_width", int'(coin_d), 0);
            check("busy_at_coin", int'(busy), 1);
            if (coin_q.size() == 0) begin
                check("unexpected_coin", 1, 0);
            end else begin
                exp_mode = coin_q.pop_front();
                check("mode_at_coin", int'(mode), exp_mode);
            end
            coin_cyc = cyc;
        end
        if (refund_pulse) begin
            if (burst_pulses > 0) check("refund_spacing", cyc - last_pulse_cyc, 4);
            else first_pulse_cyc = cyc;
            burst_pulses++;
            last_pulse_cyc = cyc;
        end
        if (coin_reject) begin
            check("reject_width", int'(reject_d), 0);
            check("reject_expected", int'(reject_q.size() > 0), 1);
            if (reject_q.size() > 0) void'(reject_q.pop_front());
        end
        if (busy_d && !busy) begin
            if (refund_q.size() == 0) begin
                check("unexpected_episode_end", 1, 0);
            end else begin
                exp_ref = refund_q.pop_front();
                check("refund_count", burst_pulses, exp_ref.count);
                if (exp_ref.first_delay > 0)
                    check("timeout_delay", first_pulse_cyc - coin_cyc, exp_ref.first_delay);
            end
            burst_pulses = 0;
        end
        busy_d   = busy;
        coin_d   = coin;
        reject_d = coin_reject;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_coin();
        coin_in = 1'b1;
        tick(2);
        coin_in = 1'b0;
        tick(2);
    endtask

    task automatic press_cancel();
        cancel_btn = 1'b1;
        tick(2);
        cancel_btn = 1'b0;
        tick(2);
    endtask

    task automatic wait_coin();
        int k = 0;
        while (!coin && k < 40) begin
            tick(1);
            k++;
        end
        if (!coin) check("coin_wait_expired", 0, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin
            tick(1);
            k++;
        end
        check("idle_wait", int'(busy), 0);
        tick(2);
    endtask

    // ending: 0 soak_op, 1 coin_rtn, 2 arm timeout, 3 user cancel in COLLECT
    task automatic run_episode(input int m, input int n, input int ending, input bit coin_in_refund);
        int p;
        int acc;
        int res;
        p = price_of(m);
        mode_key = 2'(m);
        tick(2);
        mode_key = 2'b11;
        acc = (n > 15) ? 15 : n;
        for (int i = 0; i < n; i++) begin
            if (i >= 15) reject_q.push_back(1);
            put_coin();
        end
        check("credit_collected", int'(credit), acc);
        if (ending == 3) begin
            refund_q.push_back('{acc, 0});
            press_cancel();
            if (coin_in_refund) begin
                reject_q.push_back(1);
                put_coin();
            end
        end else begin
            coin_q.push_back(m);
            idle_op = 1'b1;
            wait_coin();
            idle_op = 1'b0;
            res = acc - p;
            tick(1);
            check("credit_after_issue", int'(credit), res);
            case (ending)
                0: begin
                    refund_q.push_back('{res, 0});
                    soak_op = 1'b1;
                    tick(1);
                    soak_op = 1'b0;
                end
                1: begin
                    refund_q.push_back('{p + res, 0});
                    coin_rtn = 1'b1;
                    tick(1);
                    coin_rtn = 1'b0;
                end
                default: refund_q.push_back('{p + res, 17});
            endcase
        end
        wait_idle();
        check("credit_idle", int'(credit), 0);
        check("mode_held", int'(mode), m);
    endtask

    initial begin
        int k;
        int m;
        int e;
        int n;
        tick(3);
        check("rst_coin", int'(coin), 0);
        check("rst_mode", int'(mode), 0);
        check("rst_credit", int'(credit), 0);
        check("rst_refund", int'(refund_pulse), 0);
        check("rst_reject", int'(coin_reject), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(2);

        run_episode(0, 2, 0, 1'b0);
        run_episode(2, 7, 0, 1'b0);
        run_episode(1, 3, 1, 1'b0);
        run_episode(0, 2, 2, 1'b0);
        run_episode(2, 16, 3, 1'b1);

        for (int r = 0; r < 8; r++) begin
            m = $urandom_range(0, 2);
            e = $urandom_range(0, 3);
            n = (e == 3) ? $urandom_range(1, 6) : price_of(m) + $urandom_range(0, 4);
            run_episode(m, n, e, 1'b0);
        end

        // Asynchronous reset in the middle of a refund train.
        mode_key = 2'b01;
        tick(2);
        mode_key = 2'b11;
        for (int i = 0; i < 6; i++) put_coin();
        check("credit_before_reset", int'(credit), 6);
        refund_q.push_back('{2, 0});
        cancel_btn = 1'b1;
        tick(2);
        cancel_btn = 1'b0;
        k = 0;
        while (burst_pulses < 2 && k < 60) begin
            tick(1);
            k++;
        end
        check("pulses_before_reset", burst_pulses, 2);
        #3 rst_n = 1'b0;
        #1;
        check("areset_coin", int'(coin), 0);
        check("areset_mode", int'(mode), 0);
        check("areset_credit", int'(credit), 0);
        check("areset_refund", int'(refund_pulse), 0);
        check("areset_reject", int'(coin_reject), 0);
        check("areset_busy", int'(busy), 0);
        tick(3);
        rst_n = 1'b1;
        tick(30);
        check("pulses_after_reset", burst_pulses, 0);
        check("busy_after_reset", int'(busy), 0);

        // Cancel held high counts as a single event.
        for (int i = 0; i < 2; i++) put_coin();
        refund_q.push_back('{2, 0});
        cancel_btn = 1'b1;
        tick(6);
        wait_idle();
        for (int i = 0; i < 3; i++) put_coin();
        tick(4);
        check("credit_cancel_held", int'(credit), 3);
        cancel_btn = 1'b0;
        tick(2);
        refund_q.push_back('{3, 0});
        press_cancel();
        wait_idle();

        tick(4);
        check("coin_q_empty", coin_q.size(), 0);
        check("refund_q_empty", refund_q.size(), 0);
        check("reject_q_empty", reject_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
